// File: rtl/cla_add_sequencer_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package cla_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/cla_add_sequencer_if.sv
// Request/response bundle between two operand requesters, the sequencer and the result consumer.
interface cla_add_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_op;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_sum, rsp_cout, rsp_id
    );

endinterface

// File: rtl/cla_add_sequencer_slice.sv
// Combinational 4-bit carry-lookahead slice with generate/propagate/kill terms.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] k;
    logic [3:0] t;
    logic [4:1] c;

    assign g = a & b;
    assign p = a ^ b;
    assign k = ~(a | b);
    // A carry passes through any bit position that does not kill it.
    assign t = ~k;

    assign c[1] = g[0] | (t[0] & cin);
    assign c[2] = g[1] | (t[1] & g[0]) | (t[1] & t[0] & cin);
    assign c[3] = g[2] | (t[2] & g[1]) | (t[2] & t[1] & g[0])
                | (t[2] & t[1] & t[0] & cin);
    assign c[4] = g[3] | (t[3] & g[2]) | (t[3] & t[2] & g[1])
                | (t[3] & t[2] & t[1] & g[0]) | (t[3] & t[2] & t[1] & t[0] & cin);

    assign s    = p ^ {c[3], c[2], c[1], cin};
    assign cout = c[4];

endmodule

// File: rtl/cla_add_sequencer.sv
// Two-requester wide add/subtract engine that time-multiplexes one 4-bit CLA slice,
// one nibble per cycle, with round-robin arbitration and a held valid/ready response.
module cla_add_sequencer
    import cla_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    cla_add_sequencer_if.slave  bus
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_t           state;
    logic             ptr;
    logic             id_q;
    logic             carry_q;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     result_q;

    logic             grant0;
    logic             grant1;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [3:0]       nib_s;
    logic             nib_cout;

    // Round-robin only matters on contention; a lone requester always wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
            grant1 = bus.req1_valid & (~bus.req0_valid |  ptr);
        end
    end

    always_comb begin
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    cla4_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .s    (nib_s),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 1'b0;
            id_q     <= 1'b0;
            carry_q  <= 1'b0;
            idx      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        // Subtraction is A + ~B + 1; the +1 enters as the initial carry.
                        if (grant1) begin
                            a_q     <= bus.req1_a;
                            b_q     <= (bus.req1_op == OP_SUB) ? ~bus.req1_b : bus.req1_b;
                            carry_q <= bus.req1_op;
                        end else begin
                            a_q     <= bus.req0_a;
                            b_q     <= (bus.req0_op == OP_SUB) ? ~bus.req0_b : bus.req0_b;
                            carry_q <= bus.req0_op;
                        end
                        id_q  <= grant1;
                        ptr   <= ~grant1;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx == IDX_W'(i)) begin
                            result_q[4*i +: 4] <= nib_s;
                        end
                    end
                    carry_q <= nib_cout;
                    if (idx == IDX_LAST) begin
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = grant0 & ~rst;
    assign bus.req1_ready = grant1 & ~rst;
    assign bus.rsp_valid  = (state == DONE);
    assign bus.rsp_sum    = result_q;
    assign bus.rsp_cout   = carry_q;
    assign bus.rsp_id     = id_q;

endmodule
